// File: rtl/instruction_pkg.sv
// Shared instruction definitions for the regex engine and the fetch arbiter
// that feeds instruction words to the engine cores.
package instruction;

  localparam int INSTRUCTION_WIDTH = 16;

  typedef enum logic [7:0] {
    ACCEPT                = 8'd0,
    SPLIT                 = 8'd1,
    MATCH                 = 8'd2,
    JMP                   = 8'd3,
    END_WITHOUT_ACCEPTING = 8'd4,
    MATCH_ANY             = 8'd5,
    ACCEPT_PARTIAL        = 8'd6
  } instr_type;

  typedef struct packed {
    instr_type  itype;
    logic [7:0] data;
  } istruction;

  // Word returned in place of a corrupt instruction: ends the thread without accepting.
  localparam logic [INSTRUCTION_WIDTH-1:0] ILLEGAL_SUBSTITUTE = {END_WITHOUT_ACCEPTING, 8'h00};

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// modulo N_REQ, so N_REQ need not be a power of two.
module round_robin_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Round-robin sharing of one single-ported instruction memory among N_REQ cores.
// Optional macro ILLEGAL_INSTR_TRAP_EN replaces out-of-range instruction types.
module instr_fetch_arbiter
  import instruction::*;
#(
  parameter int N_REQ    = 4,
  parameter int PC_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PC_WIDTH-1:0]    req_pc,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [INSTRUCTION_WIDTH-1:0] rsp_instr,
  output logic                         rsp_illegal,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic                         mem_en,
  output logic [PC_WIDTH-1:0]          mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data
);

  localparam int PTR_W = $clog2(N_REQ);

  fetch_state_t     state, state_nxt;
  logic [PTR_W-1:0] ptr, owner;
  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             arb_en, grant;
  logic             trap;

  round_robin_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef ILLEGAL_INSTR_TRAP_EN
  istruction fetched;
  assign fetched = istruction'(mem_data);
  assign trap    = fetched.itype > ACCEPT_PARTIAL;
`else
  assign trap = 1'b0;
`endif

  // Arbitration is open in IDLE and on the response handshake cycle only.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (pick_any) state_nxt = WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        if (rsp_ready[owner]) begin
          arb_en    = 1'b1;
          state_nxt = pick_any ? WAIT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant     = arb_en & pick_any;
  assign req_ready = grant ? pick_grant : '0;
  assign mem_en    = grant;
  assign mem_addr  = grant ? req_pc[pick_idx*PC_WIDTH +: PC_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      rsp_valid   <= '0;
      rsp_instr   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= pick_idx;
        ptr   <= (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == WAIT) begin
        rsp_valid   <= N_REQ'(1) << owner;
        rsp_instr   <= trap ? ILLEGAL_SUBSTITUTE : mem_data;
        rsp_illegal <= trap;
      end else if (state == RESP && rsp_ready[owner]) begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Bench for instr_fetch_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_arbiter;

  localparam int N  = 4;
  localparam int PW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*PW-1:0] req_pc;
  logic [15:0]     rsp_instr, mem_data;
  logic            rsp_illegal, mem_en;
  logic [PW-1:0]   mem_addr;
  logic [15:0]     mem [512];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_arbiter #(.N_REQ(N), .PC_WIDTH(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_instr   (rsp_instr),
    .rsp_illegal (rsp_illegal),
    .rsp_ready   (rsp_ready),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data)
  );

  // Single-ported synchronous BRAM: data the cycle after mem_en.
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  // {illegal, word} the core must receive for a stored memory word.
  function automatic logic [16:0] xlate(input logic [15:0] w);
`ifdef ILLEGAL_INSTR_TRAP_EN
    if (w[15:8] > 8'd6) return {1'b1, 16'h0400};
`endif
    return {1'b0, w};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one fetch may be in flight, one response may be pending.
  bit          armed      = 0;
  int          m_ptr      = 0;
  bit          m_fly      = 0;
  int          m_fly_core = 0;
  logic [16:0] m_fly_w    = '0;
  bit          m_out      = 0;
  int          m_out_core = 0;
  logic [16:0] m_out_w    = '0;

  always @(negedge clk) begin : model
    int win;
    bit hs, can;
    win = -1;
    hs  = m_out && rsp_ready[m_out_core];
    can = !m_fly && (!m_out || hs);
    if (can)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (armed) begin
      chk("req_ready", req_ready, (win >= 0) ? N'(1) << win : N'(0));
      chk("mem_en", mem_en, win >= 0);
      if (win >= 0) chk("mem_addr", mem_addr, req_pc[win*PW +: PW]);
      chk("rsp_valid", rsp_valid, m_out ? N'(1) << m_out_core : N'(0));
      if (m_out) begin
        chk("rsp_instr", rsp_instr, m_out_w[15:0]);
        chk("rsp_illegal", rsp_illegal, m_out_w[16]);
      end
    end
    if (rst) begin
      armed <= 1;
      m_ptr <= 0;
      m_fly <= 0;
      m_out <= 0;
    end else begin
      m_out <= m_fly ? 1'b1 : (hs ? 1'b0 : m_out);
      if (m_fly) begin
        m_out_core <= m_fly_core;
        m_out_w    <= m_fly_w;
      end
      m_fly <= (win >= 0);
      if (win >= 0) begin
        m_fly_core <= win;
        m_fly_w    <= xlate(mem[req_pc[win*PW +: PW]]);
        m_ptr      <= (win + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_pc(input int c, input logic [PW-1:0] pc);
    req_pc[c*PW +: PW] = pc;
  endtask

  // One isolated fetch from IDLE with a literal expected response.
  task automatic fetch_one(input int c, input logic [PW-1:0] pc, input logic [15:0] ew, input bit ei);
    set_pc(c, pc);
    req_valid = N'(1) << c;
    rsp_ready = '1;
    @(negedge clk);
    chk("fo_grant", req_ready, N'(1) << c);
    chk("fo_addr", mem_addr, pc);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("fo_wait_rv", rsp_valid, 0);
    cyc();
    @(negedge clk);
    chk("fo_rv", rsp_valid, N'(1) << c);
    chk("fo_instr", rsp_instr, ew);
    chk("fo_ill", rsp_illegal, ei);
    cyc();
  endtask

  initial begin
    int          order[$];
    int          when[$];
    logic [15:0] w2, w1;
    logic [N-1:0] g;

    rst       = 1'b1;
    req_valid = '0;
    req_pc    = '0;
    rsp_ready = '1;
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[9'h005] = 16'h0261;
    mem[9'h040] = 16'h0A33;
    mem[9'h041] = 16'h0612;
    do_reset();

    // reset values
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_illegal", rsp_illegal, 0);
    cyc();

    fetch_one(0, 9'h005, 16'h0261, 1'b0);
`ifdef ILLEGAL_INSTR_TRAP_EN
    fetch_one(0, 9'h040, 16'h0400, 1'b1);
`else
    fetch_one(0, 9'h040, 16'h0A33, 1'b0);
`endif
    fetch_one(0, 9'h041, 16'h0612, 1'b0);

    // all cores requesting continuously from ptr=0
    do_reset();
    for (int i = 0; i < N; i++) set_pc(i, PW'(9'h100 + i));
    req_valid = '1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin order.push_back(i); when.push_back(t); end
      cyc();
    end
    chk("rr_count", order.size(), 5);
    for (int k = 0; k < 5; k++) if (order.size() > k) begin
      chk("rr_order", order[k], k % N);
      chk("rr_time", when[k], 2 * k);
    end
    req_valid = '0;
    repeat (3) cyc();

    // response backpressure on core 2 with core 3 waiting
    do_reset();
    w2 = mem[9'h0a0];
    set_pc(2, 9'h0a0);
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    @(negedge clk);
    chk("bp_grant2", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b1000;
    set_pc(3, 9'h0b0);
    @(negedge clk);
    chk("bp_wait_rdy", req_ready, 0);
    cyc();
    repeat (5) begin
      @(negedge clk);
      chk("bp_rv", rsp_valid, 4'b0100);
      chk("bp_instr", rsp_instr, xlate(w2) & 17'h0ffff);
      chk("bp_rdy", req_ready, 0);
      chk("bp_mem_en", mem_en, 0);
      cyc();
      rsp_ready = 4'($urandom) & 4'b1011;
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    chk("bp_hs_rv", rsp_valid, 4'b0100);
    chk("bp_hs_grant3", req_ready, 4'b1000);
    chk("bp_hs_mem_en", mem_en, 1);
    cyc();
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) cyc();

    // reset in WAIT after a grant to core 1
    do_reset();
    set_pc(1, 9'h077);
    set_pc(3, 9'h0c3);
    w1 = mem[9'h077];
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rw_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rw_rv_after", rsp_valid, 0);
    chk("rw_ptr0_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rw_wait_rv", rsp_valid, 0);
    cyc();
    @(negedge clk);
    chk("rw_rv", rsp_valid, 4'b0010);
    chk("rw_instr", rsp_instr, xlate(w1) & 17'h0ffff);
    chk("rw_grant3", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    repeat (3) cyc();

    // random traffic; a core holds its pc until granted, may withdraw
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      g = req_ready;
      cyc();
      rst       = ($urandom_range(0, 299) == 0);
      rsp_ready = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !g[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_pc(i, PW'($urandom));
        end
      end
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_arbiter.md
# instr_fetch_arbiter

Shares one single-ported instruction memory between `N_REQ` regex engine cores. Each core issues instruction fetch requests, and the block grants them in round-robin order. It drives the memory read and returns the 16-bit instruction (8-bit type, 8-bit data) to the winning core through a valid/ready response channel. It sits between the engine cores and the instruction BRAM.

## Interface
- `N_REQ`, 4: number of requesting cores, 2..16.
- `PC_WIDTH`, 9: instruction address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: fetch request per core.
- `req_pc` in `N_REQ`×`PC_WIDTH`: requested address per core.
- `req_ready` out `N_REQ`: one-hot acceptance, the grant.
- `rsp_valid` out `N_REQ`: one-hot response valid.
- `rsp_instr` out `INSTRUCTION_WIDTH` (16): fetched instruction, shared by all cores and qualified by `rsp_valid`.
- `rsp_illegal` out 1: instruction type out of range, qualified by `rsp_valid`.
- `rsp_ready` in `N_REQ`: core accepts response.
- `mem_en` out 1: memory read enable.
- `mem_addr` out `PC_WIDTH`: memory read address.
- `mem_data` in 16: read data, valid the cycle after `mem_en`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick winner `w` as the first set bit searching upward from `ptr`, wrapping modulo `N_REQ`.
  - Same cycle: `req_ready[w]`=1, `mem_en`=1, `mem_addr`=`req_pc[w]`, `owner`<=w, `ptr`<=(w+1) mod `N_REQ`.
  - Next state: WAIT.
- **WAIT:** capture `mem_data` into the response register. Next state: RESP.
- **RESP:**
  - `rsp_valid[owner]`=1 and `rsp_instr`=captured word, both held stable until `rsp_ready[owner]`.
  - On the handshake cycle, arbitration runs exactly as in IDLE. If a grant is made, next state is WAIT; otherwise next state is IDLE.
  - `rsp_ready` of non-owners is ignored.
- Requesters hold `req_valid`/`req_pc` stable until `req_ready`. Dropping `req_valid` before the grant is legal and simply removes the request.
- At most one `req_ready` bit and at most one `rsp_valid` bit are high in any cycle.
- Fairness:
  - `ptr` advances only on a grant.
  - A core that just won is the lowest priority at the next arbitration.
  - Any continuously requesting core is granted within `N_REQ` grants.
- `ptr` width is $clog2(`N_REQ`). The wrap is explicit, so non-power-of-2 `N_REQ` is legal.

## Timing
- Reset values: state=IDLE, `ptr`=0, `owner`=0, `req_ready`=0, `rsp_valid`=0, `rsp_instr`=16'h0000, `rsp_illegal`=0, `mem_en`=0, `mem_addr`=0.
- `req_ready` and `mem_en` are combinational from state and `req_valid`. `rsp_*` outputs are registered.
- Grant at cycle T, data at T+1, `rsp_valid` at T+2. Minimum latency is 2 cycles from grant.
- Peak throughput is one fetch per 2 cycles, with a back-to-back grant on the handshake cycle.
- Response backpressure (`rsp_ready`=0) stalls all arbitration. No new grant is made while RESP is held.
- `rst` asserted in any state: next cycle IDLE with reset values. An in-flight fetch is discarded and the requester must re-request.
- `rst` overrides any concurrent request or handshake.

## Configuration
- Macro: `ILLEGAL_INSTR_TRAP_EN`.
- **Defined:**
  - In WAIT, if `mem_data[15:8]` > `ACCEPT_PARTIAL` (6), set `rsp_illegal`=1.
  - Replace the captured word with {`END_WITHOUT_ACCEPTING`, 8'h00} = 16'h0400, so a corrupt program terminates the thread without accepting.
- **Undefined:** `mem_data` passes through unchanged and `rsp_illegal` is tied 0. The port exists in both builds.

## Structure
- Shared `instruction` package holds:
  - `INSTRUCTION_WIDTH`, `instr_type` enum and the `istruction` struct (existing).
  - New constant `ILLEGAL_SUBSTITUTE` = {`END_WITHOUT_ACCEPTING`, 8'h00}.
  - New typedef `fetch_state_t` {IDLE, WAIT, RESP}.
- One sub-module, `round_robin_picker`: combinational; inputs request vector and `ptr`; outputs one-hot grant, index and an any-request flag. Reused by other shared-resource arbiters.

## Test plan
- Single core 0 requests pc=9'h005 with memory holding 16'h0261 (MATCH 'a'): `req_ready[0]` at T, `mem_addr`=5 at T, `rsp_valid[0]` and `rsp_instr`=16'h0261 at T+2.
- All 4 cores request continuously with `ptr`=0 and `rsp_ready` all 1: grant order 0,1,2,3,0, one grant every 2 cycles.
- Core 2 owns the response with `rsp_ready[2]`=0 for 5 cycles while core 3 requests: `rsp_valid[2]` and `rsp_instr` are stable for 5 cycles, with no `req_ready[3]` and no `mem_en`; the core 3 grant occurs on the handshake cycle.
- `rst` pulsed in WAIT after a grant to core 1: `rsp_valid` stays 0, `ptr`=0, state IDLE; core 1 re-request served normally.
- With `ILLEGAL_INSTR_TRAP_EN`, memory word 16'h0A33: `rsp_instr`=16'h0400 with `rsp_illegal`=1. Without the macro: `rsp_instr`=16'h0A33 and `rsp_illegal`=0. A legal 16'h0612 gives `rsp_illegal`=0 in both builds.
